fifo_beat_packer: RTL and testbench
===================================

FIFO_BEAT_PACKER -- requirements
Module: fifo_beat_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of one FIFO word.
REQ-002 Parameter WORDS_PER_BEAT, default 4: FIFO words packed into one output beat; legal range is 2 to 16.
REQ-003 Parameter CNT_WIDTH, default 16: width of the beat-count request.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a transfer.
REQ-007 beat_num  in  CNT_WIDTH  number of beats to transfer; sampled when start is accepted.
REQ-008 fifo_rd_en  out  1  pop strobe to the FIFO read port.
REQ-009 fifo_rd_data  in  DATA_WIDTH  FIFO head word; fall-through, valid while fifo_rd_empty is 0.
REQ-010 fifo_rd_empty  in  1  FIFO empty flag.
REQ-011 m_data  out  DATA_WIDTH*WORDS_PER_BEAT  packed output beat.
REQ-012 m_valid  out  1  output beat valid.
REQ-013 m_ready  in  1  downstream accept.
REQ-014 m_last  out  1  qualifies the final beat of a transfer.
REQ-015 busy  out  1  high from start acceptance until done.
REQ-016 done  out  1  one-cycle pulse at transfer completion.

Function
REQ-017 The FSM shall have exactly three states: IDLE, GATHER and OUTPUT.
REQ-018 IDLE: start=1 with beat_num>0 shall latch beat_num into a remaining counter and enter GATHER on the next edge; busy shall rise the same edge.
REQ-019 IDLE: start=1 with beat_num=0 shall pulse done on the next cycle, stay in IDLE and issue no pops.
REQ-020 start shall be ignored while busy=1.
REQ-021 GATHER: fifo_rd_en = !fifo_rd_empty, combinationally; fifo_rd_en shall never be 1 while fifo_rd_empty=1.
REQ-022 Each pop shall capture fifo_rd_data into slice [word_idx*DATA_WIDTH +: DATA_WIDTH] and increment word_idx.
REQ-023 The first word popped in a beat shall occupy the LSB slice.
REQ-024 The pop with word_idx = WORDS_PER_BEAT-1 shall reset word_idx to 0 and move the FSM to OUTPUT.
REQ-025 Minimum latency from the last pop to m_valid=1 shall be one cycle.
REQ-026 When the FIFO goes empty mid-beat, the word_idx already gathered shall be held, with no bubble penalty beyond the empty cycles.
REQ-027 OUTPUT: m_valid=1; m_data and m_last shall stay stable until m_valid && m_ready; fifo_rd_en=0.
REQ-028 m_last=1 iff the remaining count is 1.
REQ-029 On handshake with remaining>1: decrement remaining and return to GATHER.
REQ-030 On handshake with remaining=1: go to IDLE, pulse done for one cycle, and drop busy in that same cycle.
REQ-031 Sustained throughput with a non-empty FIFO and m_ready=1 shall be one beat per WORDS_PER_BEAT+1 cycles.

Reset
REQ-032 rst_n=0 shall asynchronously force: state IDLE, word_idx 0, remaining 0, m_data 0, m_valid 0, m_last 0, busy 0, done 0, fifo_rd_en 0.
REQ-033 Reset asserted mid-transfer shall discard the partial beat; words already popped are lost, and the FIFO is not rewound.
REQ-034 The first start shall be honoured on the first clock edge after rst_n deasserts.

Structure
REQ-035 A shared package shall hold the FSM state encoding (2-bit localparams) and the default DATA_WIDTH, WORDS_PER_BEAT and CNT_WIDTH.
REQ-036 The module shall be flat, with no sub-module; the upstream FIFO is instantiated by the parent, not inside this block.

Verification
REQ-037 DATA_WIDTH=8, WPB=4; FIFO preloaded 01,02,03,04; start with beat_num=1, m_ready=1 -> exactly 4 pops, then m_data=0x04030201 with m_valid=m_last=1 for 1 cycle, then done pulse, busy=0.
REQ-038 beat_num=3, FIFO holding 12 words, m_ready=1 -> 3 beats spaced 5 cycles apart; m_last only on the 3rd; exactly 12 pops.
REQ-039 FIFO empty for 7 cycles after the 2nd word of a beat -> fifo_rd_en=0 for those 7 cycles, no pop on empty, and the beat is still correctly ordered.
REQ-040 m_ready held low 10 cycles during OUTPUT -> m_data, m_valid and m_last stable, and zero pops, for those 10 cycles.
REQ-041 start with beat_num=0 -> done on the next cycle, busy stays 0, no pops; a second start while busy -> ignored, and the pop count is unchanged.
REQ-042 rst_n pulsed low after 2 words of a beat, then a new start with beat_num=1 and 4 more words -> the output beat contains only the 4 new words, and no earlier data appears on m_data.

Source files
------------

// File: rtl/fifo_beat_packer_pkg.sv
// Shared definitions for the FIFO beat packer: FSM state encoding and
// default geometry used when the parent does not override the parameters.
package fifo_beat_packer_pkg;

    localparam int DATA_WIDTH_DEF     = 64;
    localparam int WORDS_PER_BEAT_DEF = 4;
    localparam int CNT_WIDTH_DEF      = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

endpackage

// File: rtl/fifo_beat_packer.sv
// Pops WORDS_PER_BEAT words from a fall-through FIFO, packs them LSB-first
// into one wide beat and hands it downstream with valid/ready, beat_num times.
module fifo_beat_packer
    import fifo_beat_packer_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int WORDS_PER_BEAT = WORDS_PER_BEAT_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [CNT_WIDTH-1:0]                 beat_num,
    output logic                                 fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
    input  logic                                 fifo_rd_empty,
    output logic [DATA_WIDTH*WORDS_PER_BEAT-1:0] m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_last,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IDX_W = $clog2(WORDS_PER_BEAT);

    logic [1:0]           state;
    logic [IDX_W-1:0]     word_idx;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 pop;

    // Pop only while gathering and the FIFO head is valid; never on empty.
    assign pop        = (state == ST_GATHER) && !fifo_rd_empty;
    assign fifo_rd_en = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (beat_num != '0) begin
                            remaining <= beat_num;
                            word_idx  <= '0;
                            busy      <= 1'b1;
                            state     <= ST_GATHER;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_GATHER: begin
                    if (pop) begin
                        for (int i = 0; i < WORDS_PER_BEAT; i++) begin
                            if (word_idx == IDX_W'(i)) begin
                                m_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
                            end
                        end
                        // Last word of the beat: present it on the very next cycle.
                        if (word_idx == IDX_W'(WORDS_PER_BEAT - 1)) begin
                            word_idx <= '0;
                            m_valid  <= 1'b1;
                            m_last   <= (remaining == CNT_WIDTH'(1));
                            state    <= ST_OUTPUT;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (remaining == CNT_WIDTH'(1)) begin
                            remaining <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            remaining <= remaining - CNT_WIDTH'(1);
                            state     <= ST_GATHER;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_beat_packer.sv
// Bench for fifo_beat_packer: FIFO model feeding the DUT, a reference model
// that predicts beats from pushed words, and a scoreboard monitor.
module tb_fifo_beat_packer;

    localparam int DW  = 8;
    localparam int WPB = 4;
    localparam int CW  = 16;

    typedef struct packed {
        logic [DW*WPB-1:0] data;
        logic              last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [CW-1:0]      beat_num = '0;
    logic               fifo_rd_en;
    logic [DW-1:0]      fifo_rd_data;
    logic               fifo_rd_empty;
    logic [DW*WPB-1:0]  m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic               busy;
    logic               done;

    logic [7:0] mem [0:255];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    int         pop_count = 0;
    int         cyc = 0;
    logic       empty_force = 1'b0;
    logic       ready_force = 1'b1;
    logic       rand_mode = 1'b0;
    logic       rand_empty = 1'b0;
    logic       rand_ready = 1'b1;

    exp_t       exp_q[$];
    logic [7:0] ref_q[$];
    int         hs_cyc[$];
    bit         model_busy = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    assign fifo_rd_empty = (rd_ptr == wr_ptr) || empty_force || rand_empty;
    assign fifo_rd_data  = mem[rd_ptr[7:0]];
    assign m_ready       = rand_mode ? rand_ready : ready_force;

    fifo_beat_packer #(.DATA_WIDTH(DW), .WORDS_PER_BEAT(WPB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .beat_num(beat_num),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en && !fifo_rd_empty) begin
            rd_ptr    <= rd_ptr + 1;
            pop_count <= pop_count + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        rand_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        rand_empty = rand_mode && ($urandom_range(0, 3) == 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        ref_q.push_back(b);
    endtask

    // Reference: an accepted start with n>0 consumes n*WPB queued words, LSB first.
    task automatic do_start(input int n);
        exp_t e;
        start    = 1'b1;
        beat_num = CW'(n);
        if (!model_busy && n > 0) begin
            model_busy = 1'b1;
            for (int b = 0; b < n; b++) begin
                e.data = '0;
                for (int k = 0; k < WPB; k++)
                    e.data[k*DW +: DW] = (ref_q.size() > 0) ? ref_q.pop_front() : 8'h00;
                e.last = (b == n - 1);
                exp_q.push_back(e);
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 64'(!seen), 64'd0);
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_m_data"},  64'(m_data), 64'd0);
        check({name, "_m_valid"}, 64'(m_valid), 64'd0);
        check({name, "_m_last"},  64'(m_last), 64'd0);
        check({name, "_busy"},    64'(busy), 64'd0);
        check({name, "_done"},    64'(done), 64'd0);
        check({name, "_rd_en"},   64'(fifo_rd_en), 64'd0);
    endtask

    // Monitor / scoreboard
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_last = 1'b0;
    logic [DW*WPB-1:0] prev_data = '0;
    int                done_due = 0;
    exp_t              mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            done_due   = 0;
        end else begin
            check("rd_en_while_empty", 64'(fifo_rd_en && fifo_rd_empty), 64'd0);
            if (m_valid) check("rd_en_in_output", 64'(fifo_rd_en), 64'd0);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(prev_data));
                check("hold_last", 64'(m_last), 64'(prev_last));
            end
            if (done_due == 1) begin
                check("done_after_last", 64'(done), 64'd1);
                check("busy_drop_with_done", 64'(busy), 64'd0);
                done_due = 2;
            end else if (done_due == 2) begin
                check("done_one_cycle", 64'(done), 64'd0);
                done_due = 0;
            end
            if (m_valid && m_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(mon_e.data));
                    check("beat_last", 64'(m_last), 64'(mon_e.last));
                    if (mon_e.last) begin
                        model_busy = 1'b0;
                        done_due   = 1;
                    end
                end
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_last  = m_last;
            prev_data  = m_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  pc;
        bit  got;
        logic [DW*WPB-1:0] snap;

        #1 rst_n = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        tick();
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat, start on the first edge after reset release
        base = pop_count;
        do_start(1);
        check("busy_after_first_start", 64'(busy), 64'd1);
        repeat (4) tick();
        check("single_pops", 64'(pop_count - base), 64'd4);
        check("single_valid", 64'(m_valid), 64'd1);
        check("single_last", 64'(m_last), 64'd1);
        check("single_data", 64'(m_data), 64'h04030201);
        tick();
        check("single_valid_drop", 64'(m_valid), 64'd0);
        check("single_done", 64'(done), 64'd1);
        check("single_busy", 64'(busy), 64'd0);
        tick();

        // Three back-to-back beats
        for (int i = 0; i < 12; i++) push_word(8'($urandom));
        hs_cyc.delete();
        base = pop_count;
        do_start(3);
        wait_done(100, "three_beats");
        check("three_pops", 64'(pop_count - base), 64'd12);
        check("three_hs_count", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("beat_spacing_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd5);
            check("beat_spacing_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd5);
        end

        // FIFO runs dry after the second word of a beat
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        base = pop_count;
        do_start(1);
        got = 1'b0;
        repeat (20) begin
            if (pop_count == base + 2) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("starve_reached_two", 64'(got), 64'd1);
        empty_force = 1'b1;
        repeat (7) begin
            @(negedge clk);
            check("starve_no_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        check("starve_pops_held", 64'(pop_count - base), 64'd2);
        tick();
        empty_force = 1'b0;
        wait_done(50, "starve");
        check("starve_pops_total", 64'(pop_count - base), 64'd4);

        // Downstream stall for 10 cycles
        ready_force = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        do_start(1);
        repeat (20) begin
            if (m_valid) break;
            tick();
        end
        check("stall_valid_seen", 64'(m_valid), 64'd1);
        snap = m_data;
        pc   = pop_count;
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", 64'(m_valid), 64'd1);
            check("stall_data", 64'(m_data), 64'(snap));
            check("stall_last", 64'(m_last), 64'd1);
            check("stall_no_pop", 64'(pop_count), 64'(pc));
        end
        tick();
        ready_force = 1'b1;
        wait_done(20, "stall");

        // Zero-length request and start while busy
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        base = pop_count;
        do_start(0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        tick();
        check("zero_done_drop", 64'(done), 64'd0);
        check("zero_no_pop", 64'(pop_count - base), 64'd0);
        empty_force = 1'b1;
        do_start(1);
        check("busy_accept", 64'(busy), 64'd1);
        do_start(5);
        check("busy_ignore_busy", 64'(busy), 64'd1);
        check("busy_ignore_pops", 64'(pop_count - base), 64'd0);
        empty_force = 1'b0;
        wait_done(50, "busy_ignore");
        repeat (5) tick();
        check("busy_ignore_total_pops", 64'(pop_count - base), 64'd4);
        check("busy_ignore_idle", 64'(busy), 64'd0);

        // Reset in the middle of a beat
        push_word(8'hAA);
        push_word(8'hBB);
        base = pop_count;
        do_start(1);
        got = 1'b0;
        repeat (20) begin
            if (pop_count == base + 2) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("midreset_reached_two", 64'(got), 64'd1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midreset");
        exp_q.delete();
        ref_q.delete();
        model_busy = 1'b0;
        for (int p = rd_ptr; p < wr_ptr; p++) ref_q.push_back(mem[p[7:0]]);
        for (int i = 1; i <= 4; i++) push_word(8'(8'h11 * i));
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1);
        check("midreset_restart_busy", 64'(busy), 64'd1);
        repeat (4) tick();
        check("midreset_new_data", 64'(m_data), 64'h44332211);
        wait_done(20, "midreset");

        // Randomized transfers with random FIFO starvation and backpressure
        rand_mode = 1'b1;
        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(1, 4);
            base = pop_count;
            for (int i = 0; i < n * WPB; i++) push_word(8'($urandom));
            do_start(n);
            wait_done(800, "random_xfer");
            check("random_pops", 64'(pop_count - base), 64'(n * WPB));
            check("random_sb_drained", 64'(exp_q.size()), 64'd0);
        end
        rand_mode = 1'b0;
        repeat (3) tick();
        check("final_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
